// File: rtl/psec5_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psec5_readout_pkg
// Brief    : Shared state encoding and word geometry for the counter readout.
// Revision : 1.0
// ============================================================================
package psec5_readout_pkg;

    localparam int NUM_BYTES     = 7;
    localparam int BITS_PER_BYTE = 8;
    localparam int CNT_WIDTH     = 10;
    localparam int WORD_WIDTH    = 56;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        GAP     = 3'd2,
        SCLK_HI = 3'd3,
        SCLK_LO = 3'd4,
        DONE    = 3'd5
    } rdo_state_t;

endpackage
`default_nettype wire

// File: rtl/psec5_sclk_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : psec5_sclk_phase_gen
// Brief    : Half-period phase counter and registered SPI clock level.
// Revision : 1.0
// ============================================================================
module psec5_sclk_phase_gen #(
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_sclk_next,
    output logic o_phase_end,
    output logic o_sclk
);

    localparam int c_PHASE_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [c_PHASE_W-1:0] r_phase;
    logic                 r_sclk;

    assign o_phase_end = i_run && (r_phase == c_PHASE_W'(HALF_PERIOD - 1));
    assign o_sclk      = r_sclk;

    // Counter idles at zero so every phase starts with a full half period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_sclk  <= 1'b0;
        end else begin
            r_sclk <= i_sclk_next;
            if (!i_run || o_phase_end) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/psec5_cnt_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : psec5_cnt_readout_ctrl
// Brief    : Byte-wise serial readout of the channel counters with handshake.
// Revision : 1.0
// ============================================================================
module psec5_cnt_readout_ctrl
    import psec5_readout_pkg::*;
#(
    parameter int HALF_PERIOD = 2,
    parameter int LOAD_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic       DATA_READY,
    input  logic       CNT_SER,
    output logic       LOAD_CNT_SER,
    output logic [2:0] SELECT_REG,
    output logic       SPI_CLK,
    output logic       BUSY,
    output logic       DATA_VALID,
    output logic [9:0] CA_OUT,
    output logic [9:0] CB_OUT,
    output logic [9:0] CC_OUT,
    output logic [9:0] CD_OUT,
    output logic [9:0] CE_OUT,
    output logic       FRAME_ERR
);

    localparam int c_LD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    rdo_state_t              r_state;
    rdo_state_t              w_next;
    logic [c_LD_W-1:0]       r_ld;
    logic [2:0]              r_byte;
    logic [2:0]              r_bit;
    logic [WORD_WIDTH-1:0]   r_word;
    logic                    r_load;
    logic                    r_busy;
    logic                    r_valid;
    logic                    r_ferr;
    logic [CNT_WIDTH-1:0]    r_ca, r_cb, r_cc, r_cd, r_ce;

    logic w_phase_end;
    logic w_run;
    logic w_start_ok;
    logic w_last_bit;
    logic w_last_byte;
    logic w_abort;

    assign w_run       = (r_state == SCLK_HI) || (r_state == SCLK_LO);
    assign w_start_ok  = START && !ABORT && !(r_valid && !DATA_READY);
    assign w_last_bit  = (r_bit == 3'(BITS_PER_BYTE - 1));
    assign w_last_byte = (r_byte == 3'(NUM_BYTES - 1));
    assign w_abort     = ABORT && (r_state != IDLE);

    psec5_sclk_phase_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_phase (
        .clk         (CLK),
        .rst         (RST),
        .i_run       (w_run),
        .i_sclk_next (w_next == SCLK_HI),
        .o_phase_end (w_phase_end),
        .o_sclk      (SPI_CLK)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_next = LOAD;
            LOAD:    if (r_ld == c_LD_W'(LOAD_CYCLES - 1)) w_next = GAP;
            GAP:     w_next = SCLK_HI;
            SCLK_HI: if (w_phase_end) w_next = SCLK_LO;
            SCLK_LO: begin
                if (w_phase_end) begin
                    if (!w_last_bit) begin
                        w_next = SCLK_HI;
                    end else if (!w_last_byte) begin
                        w_next = LOAD;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort) begin
            w_next = IDLE;
        end
    end

    // Strobe, busy and shift position are all registered from the next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ld    <= '0;
            r_byte  <= '0;
            r_bit   <= '0;
            r_word  <= '0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ca    <= '0;
            r_cb    <= '0;
            r_cc    <= '0;
            r_cd    <= '0;
            r_ce    <= '0;
        end else begin
            r_load <= (w_next == LOAD);
            r_busy <= (w_next != IDLE);
            r_ld   <= ((r_state == LOAD) && (w_next == LOAD)) ? r_ld + 1'b1 : '0;

            if (w_next == IDLE) begin
                r_byte <= '0;
                r_bit  <= '0;
            end else if ((r_state == SCLK_LO) && w_phase_end) begin
                r_bit <= r_bit + 1'b1;
                if (w_last_bit && !w_last_byte) begin
                    r_byte <= r_byte + 1'b1;
                end
            end

            if ((r_state == IDLE) && (w_next == LOAD)) begin
                r_word <= '0;
            end else if ((r_state == SCLK_HI) && w_phase_end && !w_abort) begin
                r_word[{r_byte, r_bit}] <= CNT_SER;
            end

            if ((r_state == DONE) && !w_abort) begin
                r_valid <= 1'b1;
                r_ca    <= r_word[9:0];
                r_cb    <= r_word[19:10];
                r_cc    <= r_word[29:20];
                r_cd    <= r_word[39:30];
                r_ce    <= r_word[49:40];
                r_ferr  <= |r_word[55:50];
            end else if (r_valid && DATA_READY) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign LOAD_CNT_SER = r_load;
    assign SELECT_REG   = r_byte;
    assign BUSY         = r_busy;
    assign DATA_VALID   = r_valid;
    assign CA_OUT       = r_ca;
    assign CB_OUT       = r_cb;
    assign CC_OUT       = r_cc;
    assign CD_OUT       = r_cd;
    assign CE_OUT       = r_ce;
    assign FRAME_ERR    = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_psec5_cnt_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_psec5_cnt_readout_ctrl
// Brief    : Directed bench with a behavioural channel-block shift model.
// Revision : 1.0
// ============================================================================
module tb_psec5_cnt_readout_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    localparam logic [9:0] c_CA = 10'h155;
    localparam logic [9:0] c_CB = 10'h2AA;
    localparam logic [9:0] c_CC = 10'h3FF;
    localparam logic [9:0] c_CD = 10'h001;
    localparam logic [9:0] c_CE = 10'h200;

    // Instance 0: default timing; instance 1: HALF_PERIOD=4, LOAD_CYCLES=1
    logic       START0 = 0, ABORT0 = 0, READY0 = 0, CNT_SER0;
    logic       LOAD0, SPI_CLK0, BUSY0, VALID0, FERR0;
    logic [2:0] SEL0;
    logic [9:0] CA0, CB0, CC0, CD0, CE0;

    logic       START1 = 0, CNT_SER1;
    logic       LOAD1, SPI_CLK1, BUSY1, VALID1, FERR1;
    logic [2:0] SEL1;
    logic [9:0] CA1, CB1, CC1, CD1, CE1;

    psec5_cnt_readout_ctrl u_dut0 (
        .CLK(CLK), .RST(RST), .START(START0), .ABORT(ABORT0), .DATA_READY(READY0),
        .CNT_SER(CNT_SER0), .LOAD_CNT_SER(LOAD0), .SELECT_REG(SEL0), .SPI_CLK(SPI_CLK0),
        .BUSY(BUSY0), .DATA_VALID(VALID0), .CA_OUT(CA0), .CB_OUT(CB0), .CC_OUT(CC0),
        .CD_OUT(CD0), .CE_OUT(CE0), .FRAME_ERR(FERR0)
    );

    psec5_cnt_readout_ctrl #(.HALF_PERIOD(4), .LOAD_CYCLES(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(START1), .ABORT(1'b0), .DATA_READY(1'b0),
        .CNT_SER(CNT_SER1), .LOAD_CNT_SER(LOAD1), .SELECT_REG(SEL1), .SPI_CLK(SPI_CLK1),
        .BUSY(BUSY1), .DATA_VALID(VALID1), .CA_OUT(CA1), .CB_OUT(CB1), .CC_OUT(CC1),
        .CD_OUT(CD1), .CE_OUT(CE1), .FRAME_ERR(FERR1)
    );

    // Channel-block model: byte load has priority, shift LSB-first on SPI_CLK fall
    logic [55:0] mword0, mword1;
    logic [7:0]  sh0, sh1;
    logic        ps0 = 0, ps1 = 0;
    always @(posedge CLK) begin
        ps0 <= SPI_CLK0;
        if (LOAD0) sh0 <= mword0[SEL0*8 +: 8];
        else if (ps0 && !SPI_CLK0) sh0 <= {1'b0, sh0[7:1]};
        ps1 <= SPI_CLK1;
        if (LOAD1) sh1 <= mword1[SEL1*8 +: 8];
        else if (ps1 && !SPI_CLK1) sh1 <= {1'b0, sh1[7:1]};
    end
    assign CNT_SER0 = sh0[0];
    assign CNT_SER1 = sh1[0];

    // Edge monitors on instance 0
    logic cnt_clr = 0;
    logic pl0 = 0, pr0 = 0;
    int   rises0 = 0, loads0 = 0, selbad0 = 0;
    always @(posedge CLK) begin
        pr0 <= SPI_CLK0;
        pl0 <= LOAD0;
        if (cnt_clr) begin
            rises0  <= 0;
            loads0  <= 0;
            selbad0 <= 0;
        end else begin
            if (SPI_CLK0 && !pr0) rises0 <= rises0 + 1;
            if (LOAD0 && !pl0) begin
                if (SEL0 != loads0[2:0]) selbad0 <= selbad0 + 1;
                loads0 <= loads0 + 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_data0(input string tag, input logic ferr);
        chk({tag, "_ca"}, 64'(CA0), 64'(c_CA));
        chk({tag, "_cb"}, 64'(CB0), 64'(c_CB));
        chk({tag, "_cc"}, 64'(CC0), 64'(c_CC));
        chk({tag, "_cd"}, 64'(CD0), 64'(c_CD));
        chk({tag, "_ce"}, 64'(CE0), 64'(c_CE));
        chk({tag, "_ferr"}, 64'(FERR0), 64'(ferr));
    endtask

    // Counts edges after the START-sampling edge until valid is seen
    task automatic wait_valid(input int inst, output int cyc);
        cyc = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge CLK); #1;
            cyc++;
            if ((inst == 0) ? VALID0 : VALID1) break;
        end
    endtask

    task automatic run0(input string tag, output int cyc);
        @(negedge CLK); START0 = 1;
        @(posedge CLK); #1; START0 = 0;
        chk({tag, "_busy"}, 64'(BUSY0), 64'd1);
        wait_valid(0, cyc);
    endtask

    task automatic wait_rises(input int n);
        int k;
        for (k = 0; k < 2000; k++) begin
            @(negedge CLK);
            if (rises0 >= n) break;
        end
        if (k == 2000) chk("rise_timeout", 64'(rises0), 64'(n));
    endtask

    task automatic accept0(input string tag);
        @(negedge CLK); READY0 = 1;
        @(posedge CLK); #1; READY0 = 0;
        chk({tag, "_valid_clr"}, 64'(VALID0), 64'd0);
    endtask

    logic [55:0] base_word;
    int          cyc;

    initial begin
        base_word = {6'b0, c_CE, c_CD, c_CC, c_CB, c_CA};
        mword0 = base_word;
        mword1 = base_word;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 64'({LOAD0, SEL0, SPI_CLK0, BUSY0, VALID0,
                                  CA0, CB0, CC0, CD0, CE0, FERR0}), 64'd0);
        @(negedge CLK); RST = 0;
        @(negedge CLK); cnt_clr = 1;
        @(negedge CLK); cnt_clr = 0;

        // Full readout with default timing
        run0("rd1", cyc);
        chk("rd1_latency", 64'(cyc), 64'd246);
        chk("rd1_busy_done", 64'(BUSY0), 64'd0);
        check_data0("rd1", 1'b0);
        chk("rd1_rises", 64'(rises0), 64'd56);
        chk("rd1_loads", 64'(loads0), 64'd7);
        chk("rd1_sel_seq", 64'(selbad0), 64'd0);

        // Back-pressure: START ignored while valid is pending
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            START0 = (i % 5 == 0);
        end
        @(negedge CLK); START0 = 0;
        chk("hold_valid", 64'(VALID0), 64'd1);
        chk("hold_busy", 64'(BUSY0), 64'd0);
        chk("hold_loads", 64'(loads0), 64'd7);
        check_data0("hold", 1'b0);

        // Accept plus START in the same cycle; word now has bit 53 set
        mword0 = base_word | (56'd1 << 53);
        @(negedge CLK); READY0 = 1; START0 = 1;
        @(posedge CLK); #1; READY0 = 0; START0 = 0;
        chk("acc_start_valid", 64'(VALID0), 64'd0);
        chk("acc_start_busy", 64'(BUSY0), 64'd1);
        wait_valid(0, cyc);
        chk("rd2_latency", 64'(cyc), 64'd246);
        check_data0("rd2", 1'b1);
        accept0("rd2");
        check_data0("rd2_kept", 1'b1);

        // Abort during byte 3, bit 4 (29th SPI_CLK rise)
        mword0 = base_word;
        @(negedge CLK); cnt_clr = 1;
        @(negedge CLK); cnt_clr = 0;
        @(negedge CLK); START0 = 1;
        @(negedge CLK); START0 = 0;
        wait_rises(29);
        chk("abort_in_hi", 64'(SPI_CLK0), 64'd1);
        chk("abort_sel", 64'(SEL0), 64'd3);
        ABORT0 = 1;
        @(posedge CLK); #1;
        chk("abort_ctrl", 64'({BUSY0, SPI_CLK0, LOAD0, VALID0}), 64'd0);
        @(negedge CLK); ABORT0 = 0;
        repeat (10) @(negedge CLK);
        chk("abort_idle", 64'({BUSY0, VALID0}), 64'd0);
        check_data0("abort_kept", 1'b1);

        // ABORT with START in IDLE: START ignored
        @(negedge CLK); ABORT0 = 1; START0 = 1;
        @(negedge CLK); ABORT0 = 0; START0 = 0;
        chk("abort_start_idle", 64'({BUSY0, LOAD0}), 64'd0);

        run0("rd3", cyc);
        chk("rd3_latency", 64'(cyc), 64'd246);
        check_data0("rd3", 1'b0);
        accept0("rd3");

        // Asynchronous reset in the middle of a high phase
        @(negedge CLK); START0 = 1;
        @(negedge CLK); START0 = 0;
        wait_rises(rises0 + 10);
        chk("rst_in_hi", 64'(SPI_CLK0), 64'd1);
        RST = 1;
        #1;
        chk("rst_async_outputs", 64'({LOAD0, SEL0, SPI_CLK0, BUSY0, VALID0,
                                      CA0, CB0, CC0, CD0, CE0, FERR0}), 64'd0);
        repeat (2) @(negedge CLK);
        RST = 0;
        run0("rd4", cyc);
        chk("rd4_latency", 64'(cyc), 64'd246);
        check_data0("rd4", 1'b0);

        // Slow-clock instance
        @(negedge CLK); START1 = 1;
        @(posedge CLK); #1; START1 = 0;
        chk("hp4_busy", 64'(BUSY1), 64'd1);
        wait_valid(1, cyc);
        chk("hp4_latency", 64'(cyc), 64'd463);
        chk("hp4_data", 64'({CE1, CD1, CC1, CB1, CA1, FERR1}),
            64'({c_CE, c_CD, c_CC, c_CB, c_CA, 1'b0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
